// File: rtl/controle_varredura_matriz.sv
// controle_varredura_matriz: column-scan controller for a 7x5 active-low LED matrix
// Ports: clk, rst_n (sync, active-low), habilita (1 = scan running),
//   coluna1..coluna5 (active-low row patterns, bit i = row i),
//   brilho (duty level 0..7, present only when BRILHO_EN is defined),
//   col_sel (one-hot column enable, bit0 = coluna1), linhas (active-low row drive),
//   frame_fim (one-cycle pulse on the first cycle of each new frame).
// Optional feature: define BRILHO_EN to add brilho and shorten the lit part of each column window.
module controle_varredura_matriz #(
  parameter int DIV_TICKS = 1000,
  parameter int BLANK_TICKS = 50,
  parameter int CNT_W = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       habilita,
  input  logic [6:0] coluna1,
  input  logic [6:0] coluna2,
  input  logic [6:0] coluna3,
  input  logic [6:0] coluna4,
  input  logic [6:0] coluna5,
`ifdef BRILHO_EN
  input  logic [2:0] brilho,
`endif
  output logic [4:0] col_sel,
  output logic [6:0] linhas,
  output logic       frame_fim
);
  typedef enum logic [1:0] {OFF, ATIVO, BLANK} estado_t;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_TICKS - 1);
  localparam logic [CNT_W-1:0] BLK_LAST = CNT_W'(BLANK_TICKS > 0 ? BLANK_TICKS - 1 : 0);
  estado_t estado, estado_n;
  logic [2:0] idx, idx_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [6:0] sombra [5];
  logic [6:0] entrada [5];
  logic carga, volta, aceso;
  logic [6:0] padrao;
  assign entrada[0] = coluna1;
  assign entrada[1] = coluna2;
  assign entrada[2] = coluna3;
  assign entrada[3] = coluna4;
  assign entrada[4] = coluna5;
  always_comb begin
    estado_n = estado;
    idx_n = idx;
    cnt_n = cnt;
    carga = 1'b0;
    volta = 1'b0;
    if (!habilita) begin
      estado_n = OFF;
      idx_n = '0;
      cnt_n = '0;
    end else if (estado != ATIVO && estado != BLANK) begin
      estado_n = ATIVO;
      idx_n = '0;
      cnt_n = '0;
      carga = 1'b1;
    end else if ((estado == ATIVO && cnt == DIV_LAST && BLANK_TICKS == 0) ||
                 (estado == BLANK && cnt == BLK_LAST)) begin
      estado_n = ATIVO;
      cnt_n = '0;
      volta = idx == 3'd4;
      carga = volta;
      idx_n = volta ? 3'd0 : idx + 3'd1;
    end else if (estado == ATIVO && cnt == DIV_LAST) begin
      estado_n = BLANK;
      cnt_n = '0;
    end else begin
      cnt_n = cnt + 1'b1;
    end
  end
  // Outputs are registered from next-state values; a fresh latch is visible on the same edge.
  assign padrao = carga ? entrada[idx_n] : sombra[idx_n];
`ifdef BRILHO_EN
  logic [2:0] brilho_r, brilho_n;
  assign brilho_n = carga ? brilho : brilho_r;
  assign aceso = 32'(cnt_n) < (((32'(brilho_n) + 32'd1) * 32'(DIV_TICKS)) >> 3);
  always_ff @(posedge clk)
    if (!rst_n) brilho_r <= 3'd7;
    else if (carga) brilho_r <= brilho;
`else
  assign aceso = 1'b1;
`endif
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado <= OFF;
      idx <= '0;
      cnt <= '0;
      for (int i = 0; i < 5; i++) sombra[i] <= 7'h7F;
      col_sel <= '0;
      linhas <= 7'h7F;
      frame_fim <= 1'b0;
    end else begin
      estado <= estado_n;
      idx <= idx_n;
      cnt <= cnt_n;
      if (carga) for (int i = 0; i < 5; i++) sombra[i] <= entrada[i];
      col_sel <= estado_n == ATIVO ? 5'd1 << idx_n : 5'd0;
      linhas <= estado_n == ATIVO && aceso ? padrao : 7'h7F;
      frame_fim <= volta;
    end
  end
endmodule

// File: tb/tb_controle_varredura_matriz.sv
// tb_controle_varredura_matriz: randomized scan check against a frame-position model
module tb_controle_varredura_matriz;
  localparam int D = 4;
  localparam int B = 1;
  localparam int P = 5 * (D + B);
  logic clk = 1'b0;
  logic rst_n, hab;
  logic [6:0] col_in [5];
  logic [4:0] col_sel;
  logic [6:0] linhas;
  logic frame_fim;
  int total = 0, bad = 0;
  bit run = 0;
  int t = 0;
  logic [6:0] pat [5];
  logic [4:0] exp_col;
  logic [6:0] exp_lin;
  logic exp_ff;
  always #5 clk = ~clk;
  controle_varredura_matriz #(.DIV_TICKS(D), .BLANK_TICKS(B), .CNT_W(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .habilita(hab),
    .coluna1(col_in[0]),
    .coluna2(col_in[1]),
    .coluna3(col_in[2]),
    .coluna4(col_in[3]),
    .coluna5(col_in[4]),
`ifdef BRILHO_EN
    .brilho(3'd7),
`endif
    .col_sel(col_sel),
    .linhas(linhas),
    .frame_fim(frame_fim)
  );
  task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%h expected=%h (t=%0d)", tag, got, want, t);
    end
  endtask
  // Model: t counts cycles since the first lit cycle; frame position follows from t alone.
  task automatic step();
    int pos;
    @(posedge clk);
    #1;
    exp_ff = 1'b0;
    if (!rst_n || !hab) run = 0;
    else if (!run) begin
      run = 1;
      t = 0;
      pat = col_in;
    end else begin
      t++;
      if (t % P == 0) begin
        exp_ff = 1'b1;
        pat = col_in;
      end
    end
    pos = t % P;
    if (run && pos % (D + B) < D) begin
      exp_col = 5'(1 << (pos / (D + B)));
      exp_lin = pat[pos / (D + B)];
    end else begin
      exp_col = 5'd0;
      exp_lin = 7'h7F;
    end
    chk("col_sel", 7'(col_sel), 7'(exp_col));
    chk("linhas", linhas, exp_lin);
    chk("frame_fim", 7'(frame_fim), 7'(exp_ff));
  endtask
  task automatic wait_pos(input int col, input bit lit);
    int n = 0;
    while (!(run && (t % P) / (D + B) == col && (((t % P) % (D + B)) < D) == lit) && n < 4 * P) begin
      step();
      n++;
    end
    total++;
    assert (n < 4 * P) else begin
      bad++;
      $error("FAIL wait_pos col=%0d got=timeout expected=reached", col);
    end
  endtask
  initial begin
    int ffs;
    rst_n = 0;
    hab = 0;
    for (int i = 0; i < 5; i++) col_in[i] = 7'h7F;
    repeat (2) step();
    rst_n = 1;
    repeat (20) step();
    col_in[0] = 7'h3C;
    col_in[4] = 7'h77;
    col_in[1] = 7'($urandom);
    col_in[2] = 7'($urandom);
    col_in[3] = 7'($urandom);
    hab = 1;
    step();
    chk("first_col", 7'(col_sel), 7'h01);
    chk("first_lin", linhas, 7'h3C);
    ffs = 0;
    for (int i = 0; i < 3 * P; i++) begin
      step();
      ffs += int'(frame_fim);
    end
    chk("ff_count", 7'(ffs), 7'd3);
    wait_pos(2, 1);
    col_in[0] = 7'h0D;
    wait_pos(0, 1);
    chk("col1_new", linhas, 7'h0D);
    wait_pos(1, 1);
    hab = 0;
    step();
    chk("drop_col", 7'(col_sel), 7'h00);
    chk("drop_ff", 7'(frame_fim), 7'h0);
    hab = 1;
    step();
    chk("reen_col", 7'(col_sel), 7'h01);
    chk("reen_lin", linhas, 7'h0D);
    wait_pos(3, 0);
    rst_n = 0;
    step();
    chk("rst_lin", linhas, 7'h7F);
    rst_n = 1;
    step();
    chk("rst_restart", 7'(col_sel), 7'h01);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(5) == 0) col_in[$urandom_range(4)] = 7'($urandom);
      hab = $urandom_range(39) != 0;
      rst_n = $urandom_range(149) != 0;
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
